// File: rtl/ml_p2s_serializer.sv
// ml_p2s_serializer: buffers ML FIFO bursts and shifts the bytes out MSB-first at a programmable bit period
module ml_p2s_serializer #(
  parameter int AW    = 9,
  parameter int DIV_W = 16
) (
  input  logic             i_clk100m,
  input  logic             i_rst_n,
  input  logic             i_p2s_rstn,
  input  logic [15:0]      i_burst_len,
  input  logic [DIV_W-1:0] i_bit_div,
  input  logic             i_ml_rd_en,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_ml_rd_flag,
  output logic             o_sdata,
  output logic             o_sbit_stb,
  output logic             o_sactive,
  output logic             o_ovf,
  output logic [AW:0]      o_level
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  typedef enum logic [1:0] {REQ_IDLE, REQ_ASSERT, REQ_COLLECT} req_t;
  typedef enum logic {S_IDLE, S_SHIFT} ser_t;
  req_t             req_st;
  ser_t             s_st;
  logic [7:0]       mem [2**AW];
  logic [AW:0]      wr_ptr, rd_ptr, free;
  logic [15:0]      blen, bcnt;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div, div_cnt, div_ld;
  logic             full, last, pop, wr;
  assign o_level      = wr_ptr - rd_ptr;
  assign free         = DEPTH - o_level;
  assign full         = o_level == DEPTH;
  assign last         = s_st == S_SHIFT && div_cnt == div - 1'b1 && bit_cnt == 3'd0;
  // a pop at full frees the slot the simultaneous write lands in
  assign pop          = o_level != '0 && (s_st == S_IDLE || last);
  assign wr           = i_byte_valid && (!full || pop);
  assign div_ld       = i_bit_div == '0 ? DIV_W'(1) : i_bit_div;
  assign o_ml_rd_flag = req_st == REQ_ASSERT;
  assign o_sactive    = s_st == S_SHIFT;
  assign o_sdata      = o_sactive & shreg[7];
  assign o_sbit_stb   = o_sactive && div_cnt == '0;
  always_ff @(posedge i_clk100m)
    if (wr && i_p2s_rstn) mem[wr_ptr[AW-1:0]] <= i_byte;
  always_ff @(posedge i_clk100m or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_ovf  <= 1'b0;
    end else if (!i_p2s_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (i_byte_valid && !wr) o_ovf <= 1'b1;
    end
  // collection counts FIFO data, not enables, since data lags i_ml_rd_en
  always_ff @(posedge i_clk100m or negedge i_rst_n)
    if (!i_rst_n) begin
      req_st <= REQ_IDLE;
      blen   <= '0;
      bcnt   <= '0;
    end else if (!i_p2s_rstn) begin
      req_st <= REQ_IDLE;
      blen   <= '0;
      bcnt   <= '0;
    end else begin
      unique case (req_st)
        REQ_IDLE:
          if (i_burst_len != '0 && int'(free) >= int'(i_burst_len)) begin
            req_st <= REQ_ASSERT;
            blen   <= i_burst_len;
          end
        REQ_ASSERT:
          if (i_ml_rd_en) begin
            req_st <= REQ_COLLECT;
            bcnt   <= '0;
          end
        REQ_COLLECT:
          if (bcnt == blen) req_st <= REQ_IDLE;
          else if (i_byte_valid) bcnt <= bcnt + 1'b1;
        default: req_st <= REQ_IDLE;
      endcase
    end
  always_ff @(posedge i_clk100m or negedge i_rst_n)
    if (!i_rst_n) begin
      s_st    <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div     <= '0;
      div_cnt <= '0;
    end else if (!i_p2s_rstn) begin
      s_st    <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div     <= '0;
      div_cnt <= '0;
    end else if (pop) begin
      s_st    <= S_SHIFT;
      shreg   <= mem[rd_ptr[AW-1:0]];
      div     <= div_ld;
      bit_cnt <= 3'd7;
      div_cnt <= '0;
    end else if (s_st == S_SHIFT) begin
      if (div_cnt == div - 1'b1) begin
        div_cnt <= '0;
        if (bit_cnt == 3'd0) s_st <= S_IDLE;
        else begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
        end
      end else div_cnt <= div_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ml_p2s_serializer.sv
// tb_ml_p2s_serializer: scoreboard bench; every accepted byte becomes eight expected MSB-first bits
module tb_ml_p2s_serializer;
  logic        clk = 0, rst_n = 0, p2s_rstn = 1, rd_en = 0, bv = 0;
  logic [15:0] blen = 0, bdiv = 0;
  logic [7:0]  byt = 0;
  logic        flag, sdata, stb, sactive, ovf;
  logic [9:0]  level;
  typedef struct {logic b; int gap;} exp_t;
  exp_t q[$];
  exp_t e;
  int   checks = 0, fails = 0, strobes = 0, since = 0;
  bit   chk_en = 0;

  ml_p2s_serializer dut (
    .i_clk100m(clk), .i_rst_n(rst_n), .i_p2s_rstn(p2s_rstn), .i_burst_len(blen),
    .i_bit_div(bdiv), .i_ml_rd_en(rd_en), .i_byte(byt), .i_byte_valid(bv),
    .o_ml_rd_flag(flag), .o_sdata(sdata), .o_sbit_stb(stb), .o_sactive(sactive),
    .o_ovf(ovf), .o_level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] v, input int first_gap, input int d);
    for (int i = 7; i >= 0; i--) q.push_back('{v[i], i == 7 ? first_gap : d});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] v);
    bv = 1; byt = v;
    @(negedge clk);
    bv = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || sactive) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", t < 5000, 1);
  endtask

  task automatic wait_flag(input string n);
    int t = 0;
    while (!flag && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(n, flag, 1);
  endtask

  task automatic soft_clear();
    p2s_rstn = 0;
    @(negedge clk);
    p2s_rstn = 1;
  endtask

  task automatic rand_rounds(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      int d, n;
      d = $urandom_range(0, 5);
      n = $urandom_range(3, 12);
      bdiv = 16'(d);
      for (int k = 0; k < n; k++) begin
        logic [7:0] v;
        v = 8'($urandom);
        push_byte(v, 0, d == 0 ? 1 : d);
        feed(v);
        cyc($urandom_range(0, 3));
      end
      drain();
    end
  endtask

  always @(posedge clk) begin
    #1;
    since++;
    if (stb) begin
      strobes++;
      if (chk_en) begin
        if (q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = q.pop_front();
          chk("sdata", sdata, e.b);
          if (e.gap != 0) chk("bit_period", since, e.gap);
        end
      end
      since = 0;
    end
  end

  initial begin
    int t, base;
    cyc(3);
    chk("rst_flag", flag, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_stb", stb, 0);
    chk("rst_sactive", sactive, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_level", level, 0);
    rst_n = 1;
    cyc(2);
    chk_en = 1;
    // single byte at one clock per bit, with load latency
    bdiv = 0;
    push_byte(8'hA5, 0, 1);
    feed(8'hA5);
    chk("lat_not_yet", sactive, 0);
    @(negedge clk);
    chk("lat_active", sactive, 1);
    chk("lat_first_stb", stb, 1);
    drain();
    // 20-byte burst handshake, gap-free at div 4
    blen = 20; bdiv = 4;
    wait_flag("burst_request");
    cyc(3);
    rd_en = 1;
    chk("flag_before_ack", flag, 1);
    @(negedge clk);
    rd_en = 0;
    chk("flag_drop", flag, 0);
    for (int k = 0; k < 20; k++) begin
      push_byte(8'(k), k == 0 ? 0 : 4, 4);
      feed(8'(k));
    end
    drain();
    wait_flag("rerequest");
    blen = 0;
    rand_rounds(4);
    // space check against burst length, then overflow with serializer stalled
    chk_en = 0;
    q.delete();
    soft_clear();
    bdiv = 16'hFFFF;
    for (int k = 0; k < 41; k++) feed(8'(k));
    chk("level_40", level, 40);
    blen = 473;
    cyc(3);
    chk("no_req_473", flag, 0);
    blen = 472;
    cyc(2);
    chk("req_472", flag, 1);
    for (int k = 0; k < 472; k++) feed(8'(k));
    chk("full_level", level, 512);
    chk("full_no_ovf", ovf, 0);
    feed(8'hEE);
    chk("ovf_level", level, 512);
    chk("ovf_set", ovf, 1);
    // soft clear mid-byte while collecting
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    cyc(2);
    chk("mid_byte", sactive, 1);
    soft_clear();
    chk("clr_level", level, 0);
    chk("clr_sactive", sactive, 0);
    chk("clr_flag", flag, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_sdata", sdata, 0);
    @(negedge clk);
    chk("restart_flag", flag, 1);
    blen = 0;
    // write and pop together at full
    soft_clear();
    bdiv = 100;
    base = strobes;
    for (int k = 0; k < 513; k++) feed(8'(k));
    chk("fill_level", level, 512);
    chk("fill_ovf", ovf, 0);
    t = 0;
    while (strobes < base + 8 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("eighth_strobe", strobes - base, 8);
    cyc(99);
    feed(8'h3C);
    chk("wp_level", level, 512);
    chk("wp_ovf", ovf, 0);
    chk("wp_next_stb", stb, 1);
    // asynchronous reset while shifting
    soft_clear();
    bdiv = 3;
    feed(8'hC3);
    cyc(6);
    chk("shift_before_rst", sactive, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_flag", flag, 0);
    chk("arst_sdata", sdata, 0);
    chk("arst_stb", stb, 0);
    chk("arst_sactive", sactive, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_level", level, 0);
    cyc(2);
    rst_n = 1;
    cyc(2);
    chk_en = 1;
    rand_rounds(3);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
